fetch_pc_seq: RTL

//  Fetch PC sequencer: owns the IF-stage fetch PC and the PC pair handed to ID1.

---
 rtl/fetch_pc_seq_pkg.sv | 13 +
 rtl/fetch_pc_incr.sv | 21 ++
 rtl/fetch_pc_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fetch_pc_seq_pkg.sv
// Shared definitions for the fetch PC sequencer: state encodings and reset PC.
package fetch_pc_seq_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SHADOW = 2'd1,
    PEND   = 2'd2
  } fetchState_e;

  localparam logic [47:0] UV48_00        = 48'h0000_0000_0000;
  localparam logic [47:0] RST_PC_DEFAULT = UV48_00;

endpackage

// File: rtl/fetch_pc_incr.sv
// Sequential PC adder: pc + bundle length in bytes.
// Bundle lengths outside 1..4 words are treated as a single 16-bit word.
module fetch_pc_incr #(
  parameter int PC_W = 48
) (
  input  logic [PC_W-1:0] pc,
  input  logic [2:0]      stepW,
  output logic [PC_W-1:0] pcNext
);

  logic [2:0]      stepSan;
  logic [PC_W-1:0] stepB;

  // Sanitise the word count, convert to bytes, add modulo 2^PC_W.
  always_comb begin
    stepSan = ((stepW >= 3'd1) && (stepW <= 3'd4)) ? stepW : 3'd1;
    stepB   = {{(PC_W-4){1'b0}}, stepSan, 1'b0};
    pcNext  = pc + stepB;
  end

endmodule

// File: rtl/fetch_pc_seq.sv
// Fetch PC sequencer: owns the IF fetch PC and the PC pair of the ID1 slot.
// Steps by bundle length, redirects on EX mispredicts and (optionally) on
// early pre-branches from the ID1 pre-branch decoder.
// Build option: FETCHPC_PREBRA_EN enables early pre-branch redirects; when
// undefined, idPreIsBra/idPreBraPc are ignored and only EX redirects exist.
module fetch_pc_seq
  import fetch_pc_seq_pkg::*;
#(
  parameter int              PC_W   = 48,
  parameter logic [PC_W-1:0] RST_PC = PC_W'(RST_PC_DEFAULT)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ifHold,
  input  logic [2:0]      ifStepW,
  input  logic            idPreIsBra,
  input  logic [PC_W-1:0] idPreBraPc,
  input  logic            exBraValid,
  input  logic [PC_W-1:0] exBraPc,
  output logic [PC_W-1:0] ifPc,
  output logic [PC_W-1:0] idBasePc,
  output logic [PC_W-1:0] idBraPc,
  output logic            ifFlush,
  output logic            idFlush
);

  fetchState_e     state, stateNext;
  logic [PC_W-1:0] pendPc, pendPcNext;
  logic [PC_W-1:0] ifPcNext;
  logic [PC_W-1:0] seqPc;
  logic [PC_W-1:0] redirPc;
  logic            preTake;
  logic            redirect;
  logic            idUpd;
  logic            ifFlushRaw;

  // Single adder feeds both the next fetch PC and the ID1 fall-through PC.
  fetch_pc_incr #(.PC_W(PC_W)) uIncr (
    .pc     (ifPc),
    .stepW  (ifStepW),
    .pcNext (seqPc)
  );

`ifdef FETCHPC_PREBRA_EN
  // Pre-branch is honoured only in RUN; EX overrides it in the target mux.
  assign preTake = idPreIsBra && (state == RUN);
`else
  logic unusedPre;
  assign unusedPre = ^{idPreIsBra, idPreBraPc};
  assign preTake   = 1'b0;
`endif

  assign redirect = exBraValid || preTake;
  assign redirPc  = exBraValid ? exBraPc : idPreBraPc;

  // Next-state, next-PC and ID1 update enable.
  always_comb begin
    stateNext  = state;
    ifPcNext   = ifPc;
    pendPcNext = pendPc;
    idUpd      = 1'b0;
    ifFlushRaw = 1'b0;
    case (state)
      RUN, SHADOW: begin
        if (redirect) begin
          ifFlushRaw = 1'b1;
          if (ifHold) begin
            pendPcNext = redirPc;
            stateNext  = PEND;
          end else begin
            ifPcNext  = redirPc;
            stateNext = SHADOW;
          end
        end else if (!ifHold) begin
          ifPcNext  = seqPc;
          idUpd     = 1'b1;
          stateNext = RUN;
        end
      end
      PEND: begin
        // The bundle sitting at ifPc is stale for as long as a target waits.
        ifFlushRaw = 1'b1;
        if (exBraValid) begin
          if (ifHold) begin
            pendPcNext = exBraPc;
          end else begin
            ifPcNext  = exBraPc;
            stateNext = SHADOW;
          end
        end else if (!ifHold) begin
          ifPcNext  = pendPc;
          stateNext = SHADOW;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  // Kill strobes are forced low while reset is asserted.
  assign ifFlush = reset & ifFlushRaw;
  assign idFlush = reset & exBraValid;

  // State, fetch PC, pending target and ID1 PC pair registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      ifPc     <= RST_PC;
      pendPc   <= '0;
      idBasePc <= '0;
      idBraPc  <= '0;
    end else begin
      state  <= stateNext;
      ifPc   <= ifPcNext;
      pendPc <= pendPcNext;
      if (idUpd) begin
        idBasePc <= ifPc;
        idBraPc  <= seqPc;
      end
    end
  end

endmodule
